// File: rtl/gshare_predictor_if.sv
// Predictor bus: fetch-side prediction request/response, execute-side
// feedback, plus status and statistics returned by the predictor.
interface gshare_predictor_if #(
    parameter int SCALE     = 10,
    parameter int CNT_WIDTH = 2
);
    logic [31:0]                bp_pc;
    logic                       bp_oe;
    logic                       bp_taken;
    logic [SCALE+CNT_WIDTH-1:0] bp_data;
    logic                       fb_taken;
    logic                       fb_we;
    logic [SCALE+CNT_WIDTH-1:0] fb_data;
    logic                       init_busy;
    logic [31:0]                cnt_hit;
    logic [31:0]                cnt_pred;

    // The pipeline that asks for predictions and returns outcomes.
    modport master (
        output bp_pc, bp_oe, fb_taken, fb_we, fb_data,
        input  bp_taken, bp_data, init_busy, cnt_hit, cnt_pred
    );

    // The predictor itself.
    modport slave (
        input  bp_pc, bp_oe, fb_taken, fb_we, fb_data,
        output bp_taken, bp_data, init_busy, cnt_hit, cnt_pred
    );
endinterface

// File: rtl/gshare_predictor.sv
// Gshare / bimodal branch direction predictor.
// A table of saturating counters is indexed by PC (optionally XORed with the
// non-speculative global history). Each prediction carries an {index, counter}
// snapshot down the pipeline; feedback writes the updated snapshot back, so
// the table never needs a read-modify-write. After reset the table is swept
// to weakly-not-taken one entry per cycle before predictions are served.
module gshare_predictor #(
    parameter int SCALE      = 10,
    parameter int HIST_WIDTH = 8,
    parameter int CNT_WIDTH  = 2,
    parameter int MODE       = 1
) (
    input logic              clk,
    input logic              rst,
    gshare_predictor_if.slave bus
);
    localparam int DEPTH = 1 << SCALE;
    localparam logic [CNT_WIDTH-1:0] WEAK_NT = CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t                stateQ;
    logic [SCALE-1:0]      initIdxQ;
    logic                  initBusyQ;

    logic [HIST_WIDTH-1:0] ghrQ;
    logic [HIST_WIDTH-1:0] ghrD;
    logic [31:0]           cntHitQ;
    logic [31:0]           cntPredQ;

    logic [CNT_WIDTH-1:0]  tableQ [DEPTH];
    logic [CNT_WIDTH-1:0]  ramRdQ;
    logic [SCALE-1:0]      rdIdxQ;
    logic                  rdValidQ;

    logic [SCALE-1:0]      pcIdx;
    logic [SCALE-1:0]      rdIdx;
    logic                  rdEn;
    logic                  fbAccept;
    logic [SCALE-1:0]      fbIdx;
    logic [CNT_WIDTH-1:0]  fbCnt;
    logic [CNT_WIDTH-1:0]  fbCntD;
    logic                  fbHit;
    logic                  wrEn;
    logic [SCALE-1:0]      wrIdx;
    logic [CNT_WIDTH-1:0]  wrData;
    logic                  unusedPcBits;

    assign unusedPcBits = ^{bus.bp_pc[31:2+SCALE], bus.bp_pc[1:0]};

    // Index selection, feedback counter update and table write arbitration.
    always_comb begin
        pcIdx    = bus.bp_pc[2+:SCALE];
        rdIdx    = pcIdx;
        if (MODE != 0) begin
            rdIdx = pcIdx ^ SCALE'(ghrQ);
        end
        rdEn     = bus.bp_oe && !initBusyQ;

        fbAccept = bus.fb_we && !initBusyQ;
        fbIdx    = bus.fb_data[CNT_WIDTH+:SCALE];
        fbCnt    = bus.fb_data[CNT_WIDTH-1:0];
        fbHit    = (fbCnt[CNT_WIDTH-1] == bus.fb_taken);
        fbCntD   = fbCnt;
        if (bus.fb_taken && (fbCnt != '1)) begin
            fbCntD = fbCnt + 1'b1;
        end else if (!bus.fb_taken && (fbCnt != '0)) begin
            fbCntD = fbCnt - 1'b1;
        end

        ghrD     = ghrQ;
        if (fbAccept) begin
            ghrD = (ghrQ << 1) | HIST_WIDTH'(bus.fb_taken);
        end

        wrEn     = (stateQ == INIT) || fbAccept;
        wrIdx    = (stateQ == INIT) ? initIdxQ : fbIdx;
        wrData   = (stateQ == INIT) ? WEAK_NT : fbCntD;
    end

    // Counter table: one read port, one write port, read-first on collision.
    always_ff @(posedge clk) begin
        if (rdEn) begin
            ramRdQ <= tableQ[rdIdx];
        end
        if (wrEn) begin
            tableQ[wrIdx] <= wrData;
        end
    end

    // Initialisation sweep: INIT walks every index once, then RUN until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ    <= INIT;
            initIdxQ  <= '0;
            initBusyQ <= 1'b1;
        end else begin
            case (stateQ)
                INIT: begin
                    initIdxQ <= initIdxQ + 1'b1;
                    if (initIdxQ == '1) begin
                        stateQ    <= RUN;
                        initBusyQ <= 1'b0;
                    end
                end
                RUN: begin
                    stateQ <= RUN;
                end
                default: begin
                    stateQ <= INIT;
                end
            endcase
        end
    end

    // Prediction snapshot index and validity; hold while bp_oe is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdIdxQ   <= '0;
            rdValidQ <= 1'b0;
        end else if (rdEn) begin
            rdIdxQ   <= rdIdx;
            rdValidQ <= 1'b1;
        end
    end

    // Global history and accuracy statistics, advanced only by accepted feedback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghrQ     <= '0;
            cntHitQ  <= '0;
            cntPredQ <= '0;
        end else begin
            ghrQ <= ghrD;
            if (fbAccept) begin
                cntPredQ <= cntPredQ + 32'd1;
                if (fbHit) begin
                    cntHitQ <= cntHitQ + 32'd1;
                end
            end
        end
    end

    assign bus.bp_taken  = rdValidQ & ramRdQ[CNT_WIDTH-1];
    assign bus.bp_data   = {rdIdxQ, (rdValidQ ? ramRdQ : {CNT_WIDTH{1'b0}})};
    assign bus.init_busy = initBusyQ;
    assign bus.cnt_hit   = cntHitQ;
    assign bus.cnt_pred  = cntPredQ;
endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench: a gshare instance (SCALE=4, HIST_WIDTH=4) and a bimodal
// instance (MODE=0) share clock and reset; expected values are hand-derived.
module tb_gshare_predictor;
    localparam int SCALE     = 4;
    localparam int CNT_WIDTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   testsRun    = 0;
    int   testsFailed = 0;

    gshare_predictor_if #(.SCALE(SCALE), .CNT_WIDTH(CNT_WIDTH)) gsBus ();
    gshare_predictor_if #(.SCALE(SCALE), .CNT_WIDTH(CNT_WIDTH)) bmBus ();

    gshare_predictor #(.SCALE(SCALE), .HIST_WIDTH(4), .CNT_WIDTH(CNT_WIDTH), .MODE(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (gsBus)
    );

    gshare_predictor #(.SCALE(SCALE), .HIST_WIDTH(4), .CNT_WIDTH(CNT_WIDTH), .MODE(0)) dutBimodal (
        .clk (clk),
        .rst (rst),
        .bus (bmBus)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Hard stop in case something hangs despite the bounded loops.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        gsBus.bp_pc = 32'h0; gsBus.bp_oe = 1'b0; gsBus.fb_taken = 1'b0;
        gsBus.fb_we = 1'b0;  gsBus.fb_data = '0;
        bmBus.bp_pc = 32'h0; bmBus.bp_oe = 1'b0; bmBus.fb_taken = 1'b0;
        bmBus.fb_we = 1'b0;  bmBus.fb_data = '0;
    endtask

    task automatic test_reset();
        int cycles;
        bit takenSeen;
        logic [5:0] expData;
        idleInputs();
        rst = 1'b1;
        step();
        step();
        testsRun++;
        if (gsBus.bp_taken !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_bp_taken: got %b expected 0", gsBus.bp_taken); end
        testsRun++;
        if (gsBus.bp_data !== 6'h00) begin testsFailed++; $display("[TB] FAIL reset_bp_data: got %h expected 00", gsBus.bp_data); end
        testsRun++;
        if (gsBus.cnt_pred !== 32'd0 || gsBus.cnt_hit !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset_counters: got pred %0d hit %0d expected 0 0", gsBus.cnt_pred, gsBus.cnt_hit); end
        testsRun++;
        if (gsBus.init_busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_init_busy: got %b expected 1", gsBus.init_busy); end

        rst = 1'b0;
        gsBus.bp_oe = 1'b1;
        bmBus.bp_oe = 1'b1;
        cycles = 0;
        takenSeen = 1'b0;
        while (gsBus.init_busy === 1'b1 && cycles < 100) begin
            step();
            cycles++;
            if (gsBus.bp_taken !== 1'b0) takenSeen = 1'b1;
        end
        testsRun++;
        if (cycles != 16) begin testsFailed++; $display("[TB] FAIL init_length: got %0d cycles expected 16", cycles); end
        testsRun++;
        if (takenSeen) begin testsFailed++; $display("[TB] FAIL init_taken: got bp_taken=1 during init expected 0"); end
        testsRun++;
        if (bmBus.init_busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL bimodal_init_done: got %b expected 0", bmBus.init_busy); end

        for (int i = 0; i < 16; i++) begin
            gsBus.bp_pc = 32'(i) << 2;
            step();
            expData = {4'(i), 2'b01};
            testsRun++;
            if (gsBus.bp_data !== expData) begin testsFailed++; $display("[TB] FAIL init_entry_%0d: got %h expected %h", i, gsBus.bp_data, expData); end
        end
        idleInputs();
    endtask

    task automatic test_bimodal();
        logic [1:0] expCnt;
        logic [5:0] snap;
        idleInputs();
        bmBus.bp_pc = 32'h14;
        expCnt = 2'b01;
        for (int k = 0; k < 3; k++) begin
            bmBus.bp_oe = 1'b1;
            bmBus.fb_we = 1'b0;
            step();
            testsRun++;
            if (bmBus.bp_data !== {4'h5, expCnt}) begin testsFailed++; $display("[TB] FAIL bimodal_data_%0d: got %h expected %h", k, bmBus.bp_data, {4'h5, expCnt}); end
            testsRun++;
            if (bmBus.bp_taken !== expCnt[1]) begin testsFailed++; $display("[TB] FAIL bimodal_taken_%0d: got %b expected %b", k, bmBus.bp_taken, expCnt[1]); end
            snap = bmBus.bp_data;
            bmBus.bp_oe = 1'b0;
            bmBus.fb_we = 1'b1;
            bmBus.fb_taken = 1'b1;
            bmBus.fb_data = snap;
            step();
            bmBus.fb_we = 1'b0;
            expCnt = (expCnt == 2'b11) ? 2'b11 : expCnt + 2'b01;
        end
        bmBus.bp_oe = 1'b1;
        step();
        testsRun++;
        if (bmBus.bp_data !== 6'b0101_11) begin testsFailed++; $display("[TB] FAIL bimodal_saturate: got %h expected %h", bmBus.bp_data, 6'b0101_11); end
        testsRun++;
        if (bmBus.bp_taken !== 1'b1) begin testsFailed++; $display("[TB] FAIL bimodal_saturate_taken: got %b expected 1", bmBus.bp_taken); end
        testsRun++;
        if (bmBus.cnt_pred !== 32'd3 || bmBus.cnt_hit !== 32'd2) begin testsFailed++; $display("[TB] FAIL bimodal_counts: got pred %0d hit %0d expected 3 2", bmBus.cnt_pred, bmBus.cnt_hit); end
        idleInputs();
    endtask

    task automatic test_history();
        logic seq [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        idleInputs();
        gsBus.fb_data = {4'h3, 2'b01};
        for (int k = 0; k < 4; k++) begin
            gsBus.fb_we = 1'b1;
            gsBus.fb_taken = seq[k];
            step();
        end
        gsBus.fb_we = 1'b0;
        gsBus.bp_oe = 1'b1;
        gsBus.bp_pc = 32'h40;
        step();
        testsRun++;
        if (gsBus.bp_data !== {4'hA, 2'b01}) begin testsFailed++; $display("[TB] FAIL history_index: got %h expected %h", gsBus.bp_data, {4'hA, 2'b01}); end
        gsBus.bp_pc = 32'h24;
        step();
        testsRun++;
        if (gsBus.bp_data !== {4'h3, 2'b00}) begin testsFailed++; $display("[TB] FAIL history_last_write: got %h expected %h", gsBus.bp_data, {4'h3, 2'b00}); end
        testsRun++;
        if (gsBus.cnt_pred !== 32'd4 || gsBus.cnt_hit !== 32'd2) begin testsFailed++; $display("[TB] FAIL history_counts: got pred %0d hit %0d expected 4 2", gsBus.cnt_pred, gsBus.cnt_hit); end
        idleInputs();
    endtask

    task automatic test_read_first();
        idleInputs();
        gsBus.bp_oe = 1'b1;
        gsBus.bp_pc = 32'h3C;
        gsBus.fb_we = 1'b1;
        gsBus.fb_taken = 1'b1;
        gsBus.fb_data = {4'h5, 2'b01};
        step();
        testsRun++;
        if (gsBus.bp_data !== {4'h5, 2'b01}) begin testsFailed++; $display("[TB] FAIL read_first_old: got %h expected %h", gsBus.bp_data, {4'h5, 2'b01}); end
        gsBus.fb_we = 1'b0;
        gsBus.bp_pc = 32'h00;
        step();
        testsRun++;
        if (gsBus.bp_data !== {4'h5, 2'b10} || gsBus.bp_taken !== 1'b1) begin testsFailed++; $display("[TB] FAIL read_first_new: got %h/%b expected %h/1", gsBus.bp_data, gsBus.bp_taken, {4'h5, 2'b10}); end
    endtask

    task automatic test_stall_and_counts();
        logic [1:0] cntVec [10] = '{2'b00, 2'b11, 2'b10, 2'b01, 2'b00, 2'b11, 2'b01, 2'b10, 2'b00, 2'b11};
        logic       tknVec [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        bit held;
        gsBus.bp_oe = 1'b0;
        held = 1'b1;
        for (int k = 0; k < 3; k++) begin
            gsBus.bp_pc = 32'h100 + 32'(k) * 32'h4C;
            step();
            if (gsBus.bp_data !== {4'h5, 2'b10} || gsBus.bp_taken !== 1'b1) held = 1'b0;
        end
        testsRun++;
        if (!held) begin testsFailed++; $display("[TB] FAIL stall_hold: got %h/%b expected %h/1", gsBus.bp_data, gsBus.bp_taken, {4'h5, 2'b10}); end
        for (int k = 0; k < 10; k++) begin
            gsBus.fb_we = 1'b1;
            gsBus.fb_taken = tknVec[k];
            gsBus.fb_data = {4'h1, cntVec[k]};
            step();
        end
        gsBus.fb_we = 1'b0;
        testsRun++;
        if (gsBus.cnt_pred !== 32'd15) begin testsFailed++; $display("[TB] FAIL count_pred: got %0d expected 15", gsBus.cnt_pred); end
        testsRun++;
        if (gsBus.cnt_hit !== 32'd9) begin testsFailed++; $display("[TB] FAIL count_hit: got %0d expected 9", gsBus.cnt_hit); end
        testsRun++;
        if (gsBus.bp_data !== {4'h5, 2'b10}) begin testsFailed++; $display("[TB] FAIL stall_during_fb: got %h expected %h", gsBus.bp_data, {4'h5, 2'b10}); end
        idleInputs();
    endtask

    task automatic test_reset_mid();
        int cycles;
        idleInputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 7; k++) step();
        testsRun++;
        if (gsBus.init_busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL mid_init_busy: got %b expected 1", gsBus.init_busy); end
        #2;
        rst = 1'b1;
        #1;
        testsRun++;
        if (gsBus.init_busy !== 1'b1 || gsBus.cnt_pred !== 32'd0 || gsBus.bp_data !== 6'h00) begin testsFailed++; $display("[TB] FAIL mid_init_reset: got busy %b pred %0d data %h expected 1 0 00", gsBus.init_busy, gsBus.cnt_pred, gsBus.bp_data); end
        step();
        rst = 1'b0;
        gsBus.fb_we = 1'b1;
        gsBus.fb_taken = 1'b1;
        gsBus.fb_data = {4'h2, 2'b01};
        cycles = 0;
        while (gsBus.init_busy === 1'b1 && cycles < 100) begin
            step();
            cycles++;
        end
        gsBus.fb_we = 1'b0;
        testsRun++;
        if (cycles != 16) begin testsFailed++; $display("[TB] FAIL restart_init_length: got %0d cycles expected 16", cycles); end
        testsRun++;
        if (gsBus.cnt_pred !== 32'd0 || gsBus.cnt_hit !== 32'd0) begin testsFailed++; $display("[TB] FAIL init_fb_ignored: got pred %0d hit %0d expected 0 0", gsBus.cnt_pred, gsBus.cnt_hit); end
        gsBus.bp_oe = 1'b1;
        gsBus.bp_pc = 32'h40;
        step();
        testsRun++;
        if (gsBus.bp_data !== {4'h0, 2'b01}) begin testsFailed++; $display("[TB] FAIL init_ghr_untouched: got %h expected %h", gsBus.bp_data, {4'h0, 2'b01}); end

        gsBus.bp_oe = 1'b0;
        gsBus.fb_we = 1'b1;
        gsBus.fb_taken = 1'b1;
        gsBus.fb_data = {4'h7, 2'b01};
        step();
        testsRun++;
        if (gsBus.cnt_pred !== 32'd1) begin testsFailed++; $display("[TB] FAIL run_fb_accepted: got %0d expected 1", gsBus.cnt_pred); end
        #2;
        rst = 1'b1;
        #1;
        testsRun++;
        if (gsBus.cnt_pred !== 32'd0 || gsBus.cnt_hit !== 32'd0 || gsBus.init_busy !== 1'b1 || gsBus.bp_data !== 6'h00) begin testsFailed++; $display("[TB] FAIL run_reset: got pred %0d hit %0d busy %b data %h expected 0 0 1 00", gsBus.cnt_pred, gsBus.cnt_hit, gsBus.init_busy, gsBus.bp_data); end
        step();
        rst = 1'b0;
        gsBus.fb_we = 1'b0;
        cycles = 0;
        while (gsBus.init_busy === 1'b1 && cycles < 100) begin
            step();
            cycles++;
        end
        testsRun++;
        if (cycles != 16 || gsBus.cnt_pred !== 32'd0) begin testsFailed++; $display("[TB] FAIL run_reset_restart: got %0d cycles pred %0d expected 16 0", cycles, gsBus.cnt_pred); end
        gsBus.bp_oe = 1'b1;
        gsBus.bp_pc = 32'h1C;
        step();
        testsRun++;
        if (gsBus.bp_data !== {4'h7, 2'b01}) begin testsFailed++; $display("[TB] FAIL run_reset_ghr: got %h expected %h", gsBus.bp_data, {4'h7, 2'b01}); end
        idleInputs();
    endtask

    // Test sequence.
    initial begin
        idleInputs();
        test_reset();
        test_bimodal();
        test_history();
        test_read_first();
        test_stall_and_counts();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
